dds_iq_gen: RTL and testbench
=============================

DDS_IQ_GEN -- requirements
Module: dds_iq_gen

Interface
- REQ-001: The block SHALL have parameter PHASE_W, default 24, giving the phase accumulator width in bits (legal range ROM_AW..32).
- REQ-002: The block SHALL have parameter ROM_AW, default 10, giving the full-cycle phase address width in bits (legal range 4..14).
- REQ-003: The block SHALL have parameter DW, default 12, giving the signed output sample width in bits (legal range 4..16).
- REQ-004: The block SHALL provide port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-005: The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
- REQ-006: The block SHALL provide port ce, input, 1 bit: clock enable for the accumulator and pipeline.
- REQ-007: The block SHALL provide port fcw_valid, input, 1 bit: load strobe for fcw and pof.
- REQ-008: The block SHALL provide port fcw, input, PHASE_W bits: frequency control word (unsigned phase step).
- REQ-009: The block SHALL provide port pof, input, PHASE_W bits: phase offset applied to both outputs.
- REQ-010: The block SHALL provide port sync_clr, input, 1 bit: synchronous phase restart.
- REQ-011: The block SHALL provide port sin_data, output, DW bits: two's-complement sine sample.
- REQ-012: The block SHALL provide port cos_data, output, DW bits: two's-complement cosine sample.
- REQ-013: The block SHALL provide port out_valid, output, 1 bit: high while sin_data/cos_data hold pipeline-valid samples.

Function
- REQ-014: The block SHALL capture fcw into fcw_r and pof into pof_r on a clock edge where fcw_valid=1, independent of ce and sync_clr.
- REQ-015: On each edge with ce=1 and sync_clr=0, the block SHALL update acc <= (acc + fcw_r) mod 2^PHASE_W, using the fcw_r value held before that edge; a new fcw therefore takes effect one edge after its load.
- REQ-016: Stage 1 SHALL register addr = upper ROM_AW bits of (acc + pof_r) mod 2^PHASE_W (truncation, no dither).
- REQ-017: The amplitude SHALL come from a quarter-wave table T[k], k=0..Q with Q=2^(ROM_AW-2), where T[k]=round(A*sin(pi*k/(2Q))) and A=2^(DW-1)-1; the table has Q+1 entries.
- REQ-018: Stage 2 SHALL register the folded magnitude and sign, with q=addr[ROM_AW-1:ROM_AW-2] and i=addr[ROM_AW-3:0]: q0 -> +T[i], q1 -> +T[Q-i], q2 -> -T[i], q3 -> -T[Q-i].
- REQ-019: The cosine SHALL equal the sine rule applied to (addr+Q) mod 2^ROM_AW, evaluated in parallel in the same stage.
- REQ-020: Stage 3 SHALL register the signed results onto sin_data and cos_data; negating zero SHALL yield 0.
- REQ-021: Latency SHALL be 3 ce-enabled edges from the acc value to its sample at the outputs.
- REQ-022: With ce=0, acc and all pipeline stages and outputs SHALL hold their values.
- REQ-023: out_valid SHALL rise on the 3rd ce-enabled edge after reset or sync_clr and then stay high until the next reset or sync_clr.
- REQ-024: On sync_clr=1, irrespective of ce, the block SHALL set acc=0, invalidate all pipeline stages and drive out_valid=0; sin_data/cos_data SHALL hold their values; fcw_r/pof_r SHALL be retained unless fcw_valid loads them on the same edge.
- REQ-025: Accumulator and address sums SHALL wrap modulo their widths, with no saturation flag.

Reset
- REQ-026: When rst_n=0, the block SHALL immediately clear acc, fcw_r, pof_r, all pipeline registers, sin_data, cos_data and out_valid to 0.
- REQ-027: Reset release SHALL take effect at the first clk edge with rst_n=1; reset asserted mid-stream SHALL discard all in-flight samples.

Verification (defaults PHASE_W=24, ROM_AW=10, DW=12, Q=256, A=2047)
- REQ-028: Reset, then fcw_valid with fcw=0, pof=0, ce=1 -> out_valid rises on the 3rd edge; sin=0 and cos=2047 constant thereafter.
- REQ-029: fcw=0x100000 (64 address units per edge), pof=0, ce=1 -> sin reproduces the address sequence 0,64,...,960; period 16 samples; sample 4 gives sin=2047, cos=0; sample 8 gives sin=0, cos=-2047; sample 12 gives sin=-2047, cos=0.
- REQ-030: pof=0x400000 (Q units), fcw=0 -> sin=2047, cos=0; pof=0xC00000 -> sin=-2047, cos=0.
- REQ-031: ce toggling 1,0,0,1 during a run -> outputs and out_valid frozen for the two ce=0 edges; sequence resumes with no skipped or duplicated sample.
- REQ-032: sync_clr pulsed mid-run with fcw_valid loading a new fcw on the same edge -> out_valid=0 for the next 2 ce edges, rises on the 3rd; first new sample is address pof; the step equals the new fcw.
- REQ-033: fcw=0xFFFFFF (a step of -1 LSB) with acc wrapping, plus rst_n pulsed low asynchronously between edges -> outputs and out_valid go to 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/dds_iq_gen.sv
// ---------------------------------------------------------------------------
// dds_iq_gen -- direct digital synthesizer producing quadrature (sine/cosine)
// samples from a phase accumulator and a shared quarter-wave amplitude table.
//
// Pipeline (advances only on ce=1 edges):
//   acc    : phase accumulator, acc <= acc + fcw_r
//   stage 1: addr = upper ROM_AW bits of (acc + pof_r)
//   stage 2: quadrant fold -> table magnitude + sign, for sine and cosine
//   stage 3: signed samples onto sin_data / cos_data
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   ce         clock enable for accumulator and pipeline
//   fcw_valid  load strobe for fcw and pof (independent of ce / sync_clr)
//   fcw        frequency control word (unsigned phase step, PHASE_W bits)
//   pof        phase offset applied to both outputs (PHASE_W bits)
//   sync_clr   synchronous phase restart: acc=0, pipeline invalidated
//   sin_data   two's-complement sine sample (DW bits)
//   cos_data   two's-complement cosine sample (DW bits)
//   out_valid  high while sin_data/cos_data hold pipeline-valid samples
// ---------------------------------------------------------------------------
module dds_iq_gen #(
    parameter int PHASE_W = 24,
    parameter int ROM_AW  = 10,
    parameter int DW      = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ce,
    input  logic               fcw_valid,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [PHASE_W-1:0] pof,
    input  logic               sync_clr,
    output logic [DW-1:0]      sin_data,
    output logic [DW-1:0]      cos_data,
    output logic               out_valid
);

    localparam int  Q   = 1 << (ROM_AW - 2);   // quarter-wave length
    localparam int  IW  = ROM_AW - 1;          // table index width (holds 0..Q)
    localparam int  MW  = DW - 1;              // unsigned magnitude width
    localparam int  AMP = (1 << (DW - 1)) - 1;
    localparam real PI  = 3.14159265358979323846;

    // Table entry k: round(AMP * sin(pi*k / (2Q))); argument is always >= 0.
    function automatic logic [MW-1:0] tab_entry(input int k);
        real ang;
        real amp;
        ang = PI * real'(k) / real'(2 * Q);
        amp = real'(AMP) * $sin(ang);
        return MW'($rtoi(amp + 0.5));
    endfunction

    // Quadrants 1 and 3 read the table mirrored (Q-i); quadrants 0 and 2 direct.
    function automatic logic [IW-1:0] fold_idx(input logic [1:0] quad,
                                               input logic [ROM_AW-3:0] frac);
        if (quad[0]) return IW'(Q) - IW'(frac);
        return IW'(frac);
    endfunction

    // NOTE: the quarter-wave table is constant logic driven from elaboration-time
    // values, so it has no storage and nothing to reset.
    logic [MW-1:0] qtab [0:Q];
    for (genvar k = 0; k <= Q; k++) begin : g_tab
        assign qtab[k] = tab_entry(k);
    end

    // ---------------- state ----------------
    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [PHASE_W-1:0] pof_q, pof_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [ROM_AW-1:0]  addr_q, addr_d;
    logic               v1_q, v1_d;
    logic [MW-1:0]      sin_mag_q, sin_mag_d, cos_mag_q, cos_mag_d;
    logic               sin_neg_q, sin_neg_d, cos_neg_q, cos_neg_d;
    logic               v2_q, v2_d;
    logic [DW-1:0]      sin_q, sin_d, cos_q, cos_d;
    logic               valid_q, valid_d;

    // Cosine is the sine rule at addr+Q: same fraction, quadrant advanced by one
    // (2-bit wrap handles quadrant 3 -> 0).
    logic [1:0]        sin_quad, cos_quad;
    logic [ROM_AW-3:0] frac;
    logic [IW-1:0]     sin_idx, cos_idx;

    assign sin_quad = addr_q[ROM_AW-1 -: 2];
    assign cos_quad = sin_quad + 2'd1;
    assign frac     = addr_q[ROM_AW-3:0];
    assign sin_idx  = fold_idx(sin_quad, frac);
    assign cos_idx  = fold_idx(cos_quad, frac);

    // NOTE: every variable gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        fcw_d     = fcw_q;
        pof_d     = pof_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        v1_d      = v1_q;
        sin_mag_d = sin_mag_q;
        cos_mag_d = cos_mag_q;
        sin_neg_d = sin_neg_q;
        cos_neg_d = cos_neg_q;
        v2_d      = v2_q;
        sin_d     = sin_q;
        cos_d     = cos_q;
        valid_d   = valid_q;

        if (fcw_valid) begin
            fcw_d = fcw;
            pof_d = pof;
        end

        if (sync_clr) begin
            // Restart phase and drain validity; sample registers keep their values.
            acc_d   = '0;
            v1_d    = 1'b0;
            v2_d    = 1'b0;
            valid_d = 1'b0;
        end else if (ce) begin
            acc_d     = acc_q + fcw_q;
            addr_d    = ROM_AW'((acc_q + pof_q) >> (PHASE_W - ROM_AW));
            v1_d      = 1'b1;
            sin_mag_d = qtab[sin_idx];
            cos_mag_d = qtab[cos_idx];
            sin_neg_d = sin_quad[1];
            cos_neg_d = cos_quad[1];
            v2_d      = v1_q;
            sin_d     = sin_neg_q ? ({DW{1'b0}} - {1'b0, sin_mag_q}) : {1'b0, sin_mag_q};
            cos_d     = cos_neg_q ? ({DW{1'b0}} - {1'b0, cos_mag_q}) : {1'b0, cos_mag_q};
            valid_d   = v2_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcw_q     <= '0;
            pof_q     <= '0;
            acc_q     <= '0;
            addr_q    <= '0;
            v1_q      <= 1'b0;
            sin_mag_q <= '0;
            cos_mag_q <= '0;
            sin_neg_q <= 1'b0;
            cos_neg_q <= 1'b0;
            v2_q      <= 1'b0;
            sin_q     <= '0;
            cos_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            fcw_q     <= fcw_d;
            pof_q     <= pof_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            v1_q      <= v1_d;
            sin_mag_q <= sin_mag_d;
            cos_mag_q <= cos_mag_d;
            sin_neg_q <= sin_neg_d;
            cos_neg_q <= cos_neg_d;
            v2_q      <= v2_d;
            sin_q     <= sin_d;
            cos_q     <= cos_d;
            valid_q   <= valid_d;
        end
    end

    assign sin_data  = sin_q;
    assign cos_data  = cos_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_dds_iq_gen.sv
// ---------------------------------------------------------------------------
// tb_dds_iq_gen -- self-checking bench for dds_iq_gen at default parameters.
// Reference: a phase/offset model producing full-cycle addresses, a three-deep
// history of ce-enabled addresses, and ideal sin/cos rounded to integers.
// ---------------------------------------------------------------------------
module tb_dds_iq_gen;

    localparam int  PHASE_W = 24;
    localparam int  ROM_AW  = 10;
    localparam int  DW      = 12;
    localparam int  N_ADDR  = 1 << ROM_AW;
    localparam int  AMP     = (1 << (DW - 1)) - 1;
    localparam real PI      = 3.14159265358979323846;
    localparam longint PMOD = 64'd1 << PHASE_W;

    logic               clk;
    logic               rst_n;
    logic               ce;
    logic               fcw_valid;
    logic [PHASE_W-1:0] fcw;
    logic [PHASE_W-1:0] pof;
    logic               sync_clr;
    logic [DW-1:0]      sin_data;
    logic [DW-1:0]      cos_data;
    logic               out_valid;

    dds_iq_gen #(.PHASE_W(PHASE_W), .ROM_AW(ROM_AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .fcw_valid (fcw_valid),
        .fcw       (fcw),
        .pof       (pof),
        .sync_clr  (sync_clr),
        .sin_data  (sin_data),
        .cos_data  (cos_data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    longint acc_m, fcw_m, pof_m;
    int     hist[$];   // addresses taken on the last ce-enabled edges since clear

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int ideal(input int a, input bit is_cos);
        real ang;
        ang = 2.0 * PI * real'(a) / real'(N_ADDR);
        return rnd(real'(AMP) * (is_cos ? $cos(ang) : $sin(ang)));
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        acc_m = 0;
        fcw_m = 0;
        pof_m = 0;
        hist.delete();
    endtask

    task automatic model_edge(input logic c, input logic fv, input logic sc,
                              input longint f, input longint p);
        int a;
        a = int'(((acc_m + pof_m) % PMOD) / (PMOD / N_ADDR));
        if (sc) begin
            acc_m = 0;
            hist.delete();
        end else if (c) begin
            hist.push_back(a);
            if (hist.size() > 3) void'(hist.pop_front());
            acc_m = (acc_m + fcw_m) % PMOD;
        end
        if (fv) begin
            fcw_m = f;
            pof_m = p;
        end
    endtask

    task automatic compare_model();
        bit v;
        v = (hist.size() == 3);
        check("out_valid", {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            check("sin_data", $signed(sin_data), ideal(hist[0], 1'b0));
            check("cos_data", $signed(cos_data), ideal(hist[0], 1'b1));
        end
    endtask

    // Drive one edge's inputs, advance the clock, update model, check #1 later.
    task automatic step(input logic c, input logic fv, input logic sc,
                        input logic [PHASE_W-1:0] f, input logic [PHASE_W-1:0] p);
        ce        = c;
        fcw_valid = fv;
        sync_clr  = sc;
        fcw       = f;
        pof       = p;
        @(posedge clk);
        model_edge(c, fv, sc, longint'(f), longint'(p));
        #1;
        compare_model();
    endtask

    // Asynchronous reset: checked immediately, released away from the edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        ce        = 1'b0;
        fcw_valid = 1'b0;
        sync_clr  = 1'b0;
        #1;
        check("rst sin_data", $signed(sin_data), 0);
        check("rst cos_data", $signed(cos_data), 0);
        check("rst out_valid", {31'd0, out_valid}, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- constant-output vectors ----------------
    typedef struct {
        logic [PHASE_W-1:0] pof;
        int                 exp_sin;
        int                 exp_cos;
    } vec_t;

    vec_t vecs[7];

    typedef struct {
        int s;
        int exp_sin;
        int exp_cos;
    } seq_pt_t;

    seq_pt_t seq_pts[5];

    initial begin
        vecs[0] = '{24'h000000,     0,  2047};
        vecs[1] = '{24'h400000,  2047,     0};
        vecs[2] = '{24'h800000,     0, -2047};
        vecs[3] = '{24'hC00000, -2047,     0};
        vecs[4] = '{24'h100000,   783,  1891};
        vecs[5] = '{24'h200000,  1447,  1447};
        vecs[6] = '{24'hE00000, -1447,  1447};

        seq_pts[0] = '{0,      0,  2047};
        seq_pts[1] = '{4,   2047,     0};
        seq_pts[2] = '{8,      0, -2047};
        seq_pts[3] = '{12, -2047,     0};
        seq_pts[4] = '{16,     0,  2047};

        rst_n     = 1'b1;
        ce        = 1'b0;
        fcw_valid = 1'b0;
        sync_clr  = 1'b0;
        fcw       = '0;
        pof       = '0;
        model_reset();
        #2;
        do_reset();

        // fcw=0 loaded on the first ce edge: valid on the 3rd edge, then constant.
        step(1, 1, 0, 24'h0, 24'h0);
        check("fcw0 valid e1", {31'd0, out_valid}, 0);
        step(1, 0, 0, 24'h0, 24'h0);
        check("fcw0 valid e2", {31'd0, out_valid}, 0);
        step(1, 0, 0, 24'h0, 24'h0);
        check("fcw0 valid e3", {31'd0, out_valid}, 1);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 24'h0, 24'h0);
            check("fcw0 sin", $signed(sin_data), 0);
            check("fcw0 cos", $signed(cos_data), 2047);
        end

        // Table: restart with fcw=0 and a fixed offset, check latency and value.
        for (int v = 0; v < 7; v++) begin
            step(1, 1, 1, 24'h0, vecs[v].pof);
            check("vec valid after clr", {31'd0, out_valid}, 0);
            step(1, 0, 0, 24'h0, 24'h0);
            step(1, 0, 0, 24'h0, 24'h0);
            check("vec valid e2", {31'd0, out_valid}, 0);
            step(1, 0, 0, 24'h0, 24'h0);
            check("vec valid e3", {31'd0, out_valid}, 1);
            check("vec sin", $signed(sin_data), vecs[v].exp_sin);
            check("vec cos", $signed(cos_data), vecs[v].exp_cos);
        end

        // 64 address units per edge: 16-sample period with quadrant landmarks.
        step(1, 1, 1, 24'h100000, 24'h0);
        for (int k = 1; k <= 19; k++) begin
            step(1, 0, 0, 24'h0, 24'h0);
            for (int j = 0; j < 5; j++) begin
                if (k - 3 == seq_pts[j].s) begin
                    check("ramp sin", $signed(sin_data), seq_pts[j].exp_sin);
                    check("ramp cos", $signed(cos_data), seq_pts[j].exp_cos);
                end
            end
        end

        // ce pattern 1,0,0,1: model expects held outputs then seamless resume.
        step(1, 0, 0, 24'h0, 24'h0);
        step(0, 0, 0, 24'h0, 24'h0);
        step(0, 0, 0, 24'h0, 24'h0);
        step(1, 0, 0, 24'h0, 24'h0);
        step(1, 0, 0, 24'h0, 24'h0);

        // sync_clr with a new fcw/pof on the same edge mid-run.
        step(1, 1, 1, 24'h030000, 24'h123456);
        step(1, 0, 0, 24'h0, 24'h0);
        check("clr valid e1", {31'd0, out_valid}, 0);
        step(1, 0, 0, 24'h0, 24'h0);
        check("clr valid e2", {31'd0, out_valid}, 0);
        step(1, 0, 0, 24'h0, 24'h0);
        check("clr valid e3", {31'd0, out_valid}, 1);
        check("clr first sin", $signed(sin_data), ideal(24'h123456 >> 14, 1'b0));
        for (int k = 0; k < 6; k++) step(1, 0, 0, 24'h0, 24'h0);

        // Step of -1 LSB wrapping through zero, then mid-cycle async reset.
        step(1, 1, 1, 24'hFFFFFF, 24'h0);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 24'h0, 24'h0);
        check("wrap sin before rst", $signed(sin_data), ideal(N_ADDR - 1, 1'b0));
        #3;
        do_reset();

        // Randomized run against the model.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(99, 0) < 75,
                 $urandom_range(99, 0) < 8,
                 $urandom_range(99, 0) < 3,
                 PHASE_W'($urandom),
                 PHASE_W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
